// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and counter sizing.
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_e;

    // Bit-counter width: clog2 of the operand width, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell: x - y - bin, producing difference and borrow-out.
module serial_subtractor_full_subtractor (
    input  logic i_x,
    input  logic i_y,
    input  logic i_bin,
    output logic o_d,
    output logic o_bout
);

    // Difference and borrow equations of a single subtractor stage
    always_comb begin
        o_d    = i_x ^ i_y ^ i_bin;
        o_bout = (~i_x & i_y) | (~(i_x ^ i_y) & i_bin);
    end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial W-bit subtractor: computes A - B LSB first, one bit per clock, using a
// single full-subtractor cell and a borrow flip-flop.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int unsigned W = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic         o_busy,
    output logic         o_done,
    output logic [W-1:0] o_diff,
    output logic         o_bout
);

    localparam int unsigned CW = cnt_width(W);
    localparam logic [CW-1:0] LastCnt = CW'(W - 1);

    if (W < 1 || W > 16) begin : g_bad_width
        $error("serial_subtractor: W must be within 1..16");
    end

    state_e        r_state;
    state_e        w_state_next;
    logic [W-1:0]  r_a_sh;
    logic [W-1:0]  r_b_sh;
    logic [W-1:0]  r_res;
    logic [W-1:0]  r_diff;
    logic [CW-1:0] r_cnt;
    logic          r_borrow;
    logic          r_bout;
    logic          r_done;
    logic          w_d;
    logic          w_borrow_next;
    logic [W-1:0]  w_res_shift;

    serial_subtractor_full_subtractor u_cell (
        .i_x   (r_a_sh[0]),
        .i_y   (r_b_sh[0]),
        .i_bin (r_borrow),
        .o_d   (w_d),
        .o_bout(w_borrow_next)
    );

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode; start is only honoured from idle
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (i_start) w_state_next = StShift;
            StShift: if (r_cnt == LastCnt) w_state_next = StDone;
            StDone:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    // New difference bit enters at the MSB; written this way so W=1 needs no slice
    always_comb begin
        w_res_shift        = r_res >> 1;
        w_res_shift[W-1]   = w_d;
    end

    // Operand shifters, borrow flop, bit counter and result/flag registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_a_sh   <= '0;
            r_b_sh   <= '0;
            r_res    <= '0;
            r_diff   <= '0;
            r_cnt    <= '0;
            r_borrow <= 1'b0;
            r_bout   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_a_sh   <= i_a;
                        r_b_sh   <= i_b;
                        r_borrow <= 1'b0;
                        r_cnt    <= '0;
                    end
                end
                StShift: begin
                    r_a_sh   <= r_a_sh >> 1;
                    r_b_sh   <= r_b_sh >> 1;
                    r_res    <= w_res_shift;
                    r_borrow <= w_borrow_next;
                    r_cnt    <= r_cnt + CW'(1);
                end
                StDone: begin
                    r_diff <= r_res;
                    r_bout <= r_borrow;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Busy is a pure state decode so it has no combinational path from the inputs
    always_comb begin
        o_busy = (r_state == StShift) || (r_state == StDone);
        o_done = r_done;
        o_diff = r_diff;
        o_bout = r_bout;
    end

endmodule
